// File: rtl/serial_deser_16bit_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_deser_16bit_if
//  Description : Handshake bundle for the 16-bit serial deserializer.
//                master = frame producer / word consumer, slave = deserializer.
//  Signals     : start, bit_valid, ser_in, out_ready  (master -> slave)
//                out_valid, par_out[15:0], par_err,
//                busy, overrun                        (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_deser_16bit_if;
   logic        start;
   logic        bit_valid;
   logic        ser_in;
   logic        out_ready;
   logic        out_valid;
   logic [15:0] par_out;
   logic        par_err;
   logic        busy;
   logic        overrun;

   modport master (
      output start, bit_valid, ser_in, out_ready,
      input  out_valid, par_out, par_err, busy, overrun
   );

   modport slave (
      input  start, bit_valid, ser_in, out_ready,
      output out_valid, par_out, par_err, busy, overrun
   );
endinterface
`default_nettype wire

// File: rtl/serial_deser_16bit.sv
`default_nettype none
// ============================================================================
//  Module      : serial_deser_16bit
//  Description : MSB-first serial-to-parallel deserializer with a one-word
//                output buffer (valid/ready) and a one-word holding stage.
//                Optional even-parity check selected by the macro
//                SERIAL_DESER_PARITY_CHECK_EN (frame becomes 17 bits, the
//                last one being the parity bit; par_err reports mismatch).
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                bus.slave  - start/bit_valid/ser_in/out_ready in,
//                             out_valid/par_out/par_err/busy/overrun out
//  Revision    : 1.0  initial release
// ============================================================================
module serial_deser_16bit (
   input  wire logic            clk,
   input  wire logic            rst,
   serial_deser_16bit_if.slave  bus
);

`ifdef SERIAL_DESER_PARITY_CHECK_EN
   localparam logic [4:0] c_LAST_CNT = 5'd16;
`else
   localparam logic [4:0] c_LAST_CNT = 5'd15;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t      r_state,     w_state;
   logic [15:0] r_sreg,      w_sreg;
   logic [4:0]  r_cnt,       w_cnt;
   logic [15:0] r_par_out,   w_par_out;
   logic        r_out_valid, w_out_valid;
   logic        r_par_err,   w_par_err;
   logic        r_hold_err,  w_hold_err;
   logic        r_overrun,   w_overrun;

   logic        w_buf_free;
   logic [15:0] w_done_word;
   logic        w_done_err;

   // Buffer can take a new word if empty or being drained on this edge.
   assign w_buf_free = ~r_out_valid | bus.out_ready;

`ifdef SERIAL_DESER_PARITY_CHECK_EN
   // Last bit is the parity bit: data is already complete in sreg.
   assign w_done_word = r_sreg;
   assign w_done_err  = (^r_sreg) ^ bus.ser_in;
`else
   assign w_done_word = {r_sreg[14:0], bus.ser_in};
   assign w_done_err  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_sreg      <= 16'h0000;
         r_cnt       <= 5'd0;
         r_par_out   <= 16'h0000;
         r_out_valid <= 1'b0;
         r_par_err   <= 1'b0;
         r_hold_err  <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_sreg      <= w_sreg;
         r_cnt       <= w_cnt;
         r_par_out   <= w_par_out;
         r_out_valid <= w_out_valid;
         r_par_err   <= w_par_err;
         r_hold_err  <= w_hold_err;
         r_overrun   <= w_overrun;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_sreg      = r_sreg;
      w_cnt       = r_cnt;
      w_par_out   = r_par_out;
      w_par_err   = r_par_err;
      w_hold_err  = r_hold_err;
      w_overrun   = r_overrun;
      // A consumed word drops valid unless a new word is loaded below.
      w_out_valid = r_out_valid & ~bus.out_ready;

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_sreg  = 16'h0000;
               w_cnt   = 5'd0;
               w_state = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (bus.start) begin
               // Abort: restart the frame from scratch.
               w_sreg = 16'h0000;
               w_cnt  = 5'd0;
            end else if (bus.bit_valid) begin
               if (r_cnt == c_LAST_CNT) begin
                  w_cnt = 5'd0;
                  if (w_buf_free) begin
                     w_par_out   = w_done_word;
                     w_par_err   = w_done_err;
                     w_out_valid = 1'b1;
                     w_state     = S_IDLE;
                  end else begin
                     // Park the completed word in sreg until the buffer frees.
                     w_sreg     = w_done_word;
                     w_hold_err = w_done_err;
                     w_state    = S_WAIT;
                  end
               end else begin
                  w_sreg = {r_sreg[14:0], bus.ser_in};
                  w_cnt  = r_cnt + 5'd1;
               end
            end
         end

         S_WAIT: begin
            if (bus.start | bus.bit_valid) begin
               w_overrun = 1'b1;
            end
            if (w_buf_free) begin
               w_par_out   = r_sreg;
               w_par_err   = r_hold_err;
               w_out_valid = 1'b1;
               w_state     = S_IDLE;
            end
         end

         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   assign bus.out_valid = r_out_valid;
   assign bus.par_out   = r_par_out;
   assign bus.par_err   = r_par_err;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_deser_16bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_deser_16bit
//  Description : Self-checking bench for serial_deser_16bit. Frames are built
//                from 16-bit words (plus an even-parity bit when
//                SERIAL_DESER_PARITY_CHECK_EN is defined); delivered words
//                are compared with the words that were sent.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_deser_16bit;

`ifdef SERIAL_DESER_PARITY_CHECK_EN
   localparam int c_NBITS = 17;
`else
   localparam int c_NBITS = 16;
`endif

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   int   stab_viol;
   bit   rand_rdy;

   logic [16:0] got_q[$];   // {par_err, par_out} of every transferred word
   logic [16:0] exp_q[$];

   serial_deser_16bit_if u_if ();

   serial_deser_16bit u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: record handshakes, advance, note stability violations.
   task automatic tick();
      logic        hold;
      logic [16:0] prev;
      if (rand_rdy) u_if.out_ready = 1'($urandom_range(0, 1));
      if (!rst && u_if.out_valid && u_if.out_ready)
         got_q.push_back({u_if.par_err, u_if.par_out});
      hold = !rst && u_if.out_valid && !u_if.out_ready;
      prev = {u_if.par_err, u_if.par_out};
      @(posedge clk);
      #1;
      if (hold && ({u_if.par_err, u_if.par_out} !== prev || !u_if.out_valid))
         stab_viol++;
   endtask

   // start cycle (junk on bit_valid/ser_in), then the frame bits.
   // gap_mode: 0 none, 1 one idle cycle between bits, 2 random 0..2 idles.
   task automatic send_frame(input logic [15:0] w, input int gap_mode, input logic parbit);
      u_if.start     = 1'b1;
      u_if.bit_valid = 1'b1;
      u_if.ser_in    = 1'($urandom);
      tick();
      u_if.start = 1'b0;
      for (int i = 0; i < c_NBITS; i++) begin
         int ngap;
         ngap = (gap_mode == 1 && i > 0) ? 1 :
                (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
         for (int g = 0; g < ngap; g++) begin
            u_if.bit_valid = 1'b0;
            u_if.ser_in    = 1'($urandom);
            tick();
         end
         u_if.bit_valid = 1'b1;
         u_if.ser_in    = (i < 16) ? w[15 - i] : parbit;
         tick();
      end
      u_if.bit_valid = 1'b0;
   endtask

   task automatic partial_frame(input int nbits);
      u_if.start = 1'b1;
      tick();
      u_if.start = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         u_if.bit_valid = 1'b1;
         u_if.ser_in    = 1'($urandom);
         tick();
      end
      u_if.bit_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      u_if.start     = 1'b1;
      u_if.bit_valid = 1'b1;
      u_if.ser_in    = 1'b1;
      u_if.out_ready = 1'b0;
      repeat (3) tick();
      rst        = 1'b0;
      u_if.start = 1'b0;
      n_checks++; if (u_if.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", u_if.out_valid); else n_pass++;
      n_checks++; if (u_if.par_out !== 16'h0000) $display("FAIL reset_par_out: got %h want 0000", u_if.par_out); else n_pass++;
      n_checks++; if (u_if.par_err !== 1'b0) $display("FAIL reset_par_err: got %b want 0", u_if.par_err); else n_pass++;
      n_checks++; if (u_if.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", u_if.busy); else n_pass++;
      n_checks++; if (u_if.overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", u_if.overrun); else n_pass++;
      // bit_valid without start is ignored in IDLE
      repeat (20) tick();
      u_if.bit_valid = 1'b0;
      n_checks++; if (u_if.busy !== 1'b0 || u_if.out_valid !== 1'b0)
         $display("FAIL idle_ignore_bits: got busy=%b valid=%b want 0 0", u_if.busy, u_if.out_valid); else n_pass++;
   endtask

   task automatic test_basic();
      u_if.out_ready = 1'b1;
      send_frame(16'hA5C3, 0, ^16'hA5C3);
      n_checks++; if (u_if.out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", u_if.out_valid); else n_pass++;
      n_checks++; if (u_if.par_out !== 16'hA5C3) $display("FAIL basic_par_out: got %h want a5c3", u_if.par_out); else n_pass++;
      n_checks++; if (u_if.busy !== 1'b0) $display("FAIL basic_busy: got %b want 0", u_if.busy); else n_pass++;
      n_checks++; if (u_if.par_err !== 1'b0) $display("FAIL basic_par_err: got %b want 0", u_if.par_err); else n_pass++;
      tick();
      n_checks++; if (u_if.out_valid !== 1'b0) $display("FAIL basic_drop: got %b want 0", u_if.out_valid); else n_pass++;
   endtask

   task automatic test_gaps();
      logic [15:0] w;
      w = 16'hA5C3;
      u_if.out_ready = 1'b1;
      u_if.start = 1'b1; tick(); u_if.start = 1'b0;
      for (int i = 0; i < c_NBITS - 1; i++) begin
         u_if.bit_valid = 1'b1; u_if.ser_in = (i < 16) ? w[15 - i] : ^w; tick();
         u_if.bit_valid = 1'b0; u_if.ser_in = 1'($urandom); tick();
      end
      // gaps must not have advanced the count: frame still open
      n_checks++; if (u_if.busy !== 1'b1 || u_if.out_valid !== 1'b0)
         $display("FAIL gaps_not_done: got busy=%b valid=%b want 1 0", u_if.busy, u_if.out_valid); else n_pass++;
      u_if.bit_valid = 1'b1; u_if.ser_in = (c_NBITS == 16) ? w[0] : ^w; tick();
      u_if.bit_valid = 1'b0;
      n_checks++; if (u_if.out_valid !== 1'b1 || u_if.par_out !== 16'hA5C3)
         $display("FAIL gaps_word: got valid=%b data=%h want 1 a5c3", u_if.out_valid, u_if.par_out); else n_pass++;
      tick();
   endtask

   task automatic test_backpressure();
      got_q.delete();
      u_if.out_ready = 1'b1; repeat (2) tick();
      u_if.out_ready = 1'b0;
      send_frame(16'h1234, 0, ^16'h1234);
      n_checks++; if (u_if.out_valid !== 1'b1 || u_if.par_out !== 16'h1234 || u_if.busy !== 1'b0)
         $display("FAIL bp_first: got valid=%b data=%h busy=%b want 1 1234 0", u_if.out_valid, u_if.par_out, u_if.busy); else n_pass++;
      stab_viol = 0;
      repeat (3) tick();
      send_frame(16'hBEEF, 0, ^16'hBEEF);
      n_checks++; if (u_if.busy !== 1'b1 || u_if.par_out !== 16'h1234 || stab_viol != 0)
         $display("FAIL bp_wait: got busy=%b data=%h viol=%0d want 1 1234 0", u_if.busy, u_if.par_out, stab_viol); else n_pass++;
      n_checks++; if (u_if.overrun !== 1'b0) $display("FAIL bp_no_overrun: got %b want 0", u_if.overrun); else n_pass++;
      u_if.start = 1'b1; tick(); u_if.start = 1'b0;
      n_checks++; if (u_if.overrun !== 1'b1 || u_if.busy !== 1'b1)
         $display("FAIL bp_overrun: got ovr=%b busy=%b want 1 1", u_if.overrun, u_if.busy); else n_pass++;
      u_if.out_ready = 1'b1; tick(); u_if.out_ready = 1'b0;
      n_checks++; if (u_if.out_valid !== 1'b1 || u_if.par_out !== 16'hBEEF || u_if.busy !== 1'b0)
         $display("FAIL bp_second: got valid=%b data=%h busy=%b want 1 beef 0", u_if.out_valid, u_if.par_out, u_if.busy); else n_pass++;
      u_if.out_ready = 1'b1; tick(); u_if.out_ready = 1'b0;
      n_checks++; if (u_if.out_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", u_if.out_valid); else n_pass++;
      n_checks++; if (got_q.size() != 2 || got_q[0] !== {1'b0, 16'h1234} || got_q[1] !== {1'b0, 16'hBEEF})
         $display("FAIL bp_order: got %0d words first=%h want 2 words 1234,beef", got_q.size(), (got_q.size() > 0) ? got_q[0] : 17'h0); else n_pass++;
      n_checks++; if (u_if.overrun !== 1'b1) $display("FAIL bp_sticky: got %b want 1", u_if.overrun); else n_pass++;
   endtask

   task automatic test_abort();
      u_if.out_ready = 1'b1;
      partial_frame(8);
      send_frame(16'h00FF, 0, ^16'h00FF);
      n_checks++; if (u_if.out_valid !== 1'b1 || u_if.par_out !== 16'h00FF)
         $display("FAIL abort_word: got valid=%b data=%h want 1 00ff", u_if.out_valid, u_if.par_out); else n_pass++;
      tick();
   endtask

   task automatic test_rst_mid();
      u_if.out_ready = 1'b1;
      partial_frame(10);
      rst = 1'b1; tick(); rst = 1'b0;
      n_checks++; if (u_if.busy !== 1'b0 || u_if.out_valid !== 1'b0 || u_if.par_out !== 16'h0000 || u_if.overrun !== 1'b0)
         $display("FAIL rst_mid_frame: got busy=%b valid=%b data=%h ovr=%b want 0 0 0000 0", u_if.busy, u_if.out_valid, u_if.par_out, u_if.overrun); else n_pass++;
      u_if.out_ready = 1'b0;
      send_frame(16'h1111, 0, ^16'h1111);
      send_frame(16'h2222, 0, ^16'h2222);
      u_if.bit_valid = 1'b1; tick(); u_if.bit_valid = 1'b0;
      n_checks++; if (u_if.busy !== 1'b1 || u_if.overrun !== 1'b1)
         $display("FAIL rst_setup_wait: got busy=%b ovr=%b want 1 1", u_if.busy, u_if.overrun); else n_pass++;
      rst = 1'b1; tick(); rst = 1'b0;
      n_checks++; if (u_if.busy !== 1'b0 || u_if.out_valid !== 1'b0 || u_if.par_out !== 16'h0000 || u_if.overrun !== 1'b0 || u_if.par_err !== 1'b0)
         $display("FAIL rst_in_wait: got busy=%b valid=%b data=%h ovr=%b err=%b want 0 0 0000 0 0", u_if.busy, u_if.out_valid, u_if.par_out, u_if.overrun, u_if.par_err); else n_pass++;
      got_q.delete();
      u_if.out_ready = 1'b1;
      send_frame(16'hFFFF, 0, ^16'hFFFF);
      tick();
      n_checks++; if (got_q.size() != 1 || got_q[0] !== {1'b0, 16'hFFFF})
         $display("FAIL rst_next_frame: got %0d words first=%h want 1 word ffff", got_q.size(), (got_q.size() > 0) ? got_q[0] : 17'h0); else n_pass++;
   endtask

`ifdef SERIAL_DESER_PARITY_CHECK_EN
   task automatic test_parity();
      u_if.out_ready = 1'b1;
      send_frame(16'h0001, 0, 1'b1);
      n_checks++; if (u_if.par_out !== 16'h0001 || u_if.par_err !== 1'b0)
         $display("FAIL parity_good: got data=%h err=%b want 0001 0", u_if.par_out, u_if.par_err); else n_pass++;
      tick();
      send_frame(16'h0001, 0, 1'b0);
      n_checks++; if (u_if.par_out !== 16'h0001 || u_if.par_err !== 1'b1)
         $display("FAIL parity_bad: got data=%h err=%b want 0001 1", u_if.par_out, u_if.par_err); else n_pass++;
      tick();
   endtask
`endif

   task automatic test_random();
      int timeouts;
      int guard;
      timeouts = 0;
      got_q.delete();
      exp_q.delete();
      rst = 1'b1; tick(); rst = 1'b0;   // clear sticky overrun from earlier tests
      stab_viol = 0;
      rand_rdy  = 1'b1;
      for (int n = 0; n < 40; n++) begin
         logic [15:0] w;
         logic        bad;
         guard = 0;
         while (u_if.busy && guard < 200) begin tick(); guard++; end
         if (guard >= 200) timeouts++;
         if ($urandom_range(0, 4) == 0) partial_frame(int'($urandom_range(0, c_NBITS - 1)));
         w   = 16'($urandom);
`ifdef SERIAL_DESER_PARITY_CHECK_EN
         bad = ($urandom_range(0, 3) == 0);
`else
         bad = 1'b0;
`endif
         send_frame(w, 2, (^w) ^ bad);
         exp_q.push_back({bad, w});
      end
      guard = 0;
      while (got_q.size() < exp_q.size() && guard < 500) begin tick(); guard++; end
      if (guard >= 500) timeouts++;
      rand_rdy = 1'b0;
      u_if.out_ready = 1'b0;
      n_checks++; if (timeouts != 0) $display("FAIL rand_timeout: got %0d timeouts want 0", timeouts); else n_pass++;
      n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d words want %0d", got_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL rand_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
         else n_pass++;
      end
      n_checks++; if (stab_viol != 0) $display("FAIL rand_stability: got %0d violations want 0", stab_viol); else n_pass++;
      n_checks++; if (u_if.overrun !== 1'b0) $display("FAIL rand_overrun: got %b want 0", u_if.overrun); else n_pass++;
   endtask

   initial begin
      n_checks       = 0;
      n_pass         = 0;
      stab_viol      = 0;
      rand_rdy       = 1'b0;
      rst            = 1'b1;
      u_if.start     = 1'b0;
      u_if.bit_valid = 1'b0;
      u_if.ser_in    = 1'b0;
      u_if.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_gaps();
      test_backpressure();
      test_abort();
      test_rst_mid();
`ifdef SERIAL_DESER_PARITY_CHECK_EN
      test_parity();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
